multdiv_wb_ctrl: RTL and testbench

Sequences the shared multi-cycle multiply/divide unit for the pipelined processor and arbitrates the single regfile write port between normal writeback and multdiv completion. It latches a mul/div issued from execute, stalls the front of the pipeline while the unit is busy, and pulses the unit's start control. It then writes either the result to rd, or an exception code to rstatus (r30).

---
 rtl/multdiv_wb_ctrl.sv | 155 +++++++++++++++
 tb/tb_multdiv_wb_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_wb_ctrl.sv
// Sequences the shared multiply/divide unit: latches an issued op, pulses start,
// waits for ready or timeout, then arbitrates its result onto the regfile write port.
module multdiv_wb_ctrl #(
    parameter int RSTATUS_REG  = 30,
    parameter int MUL_EXC_CODE = 4,
    parameter int DIV_EXC_CODE = 5,
    parameter int TIMEOUT_CODE = 6,
    parameter int MAX_WAIT     = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    output logic        stall,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_op_a,
    output logic [31:0] md_op_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        busy
);
    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_WRITE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d, b_q, b_d, result_q, result_d;
    logic [4:0]       rd_q, rd_d;
    logic             is_div_q, is_div_d, exc_q, exc_d, timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        port_free;
    logic [4:0]  pend_addr;
    logic [31:0] pend_data;

    // A pipeline write to r0 is a no-op, so it does not block the multdiv write.
    assign port_free = !wb_we || (wb_rd == 5'd0);
    assign pend_addr = (timeout_q || exc_q) ? 5'(RSTATUS_REG) : rd_q;
    assign pend_data = timeout_q ? 32'(TIMEOUT_CODE) :
                       exc_q     ? (is_div_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE)) :
                                   result_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            is_div_q  <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            is_div_q  <= is_div_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        is_div_d  = is_div_q;
        result_d  = result_q;
        exc_d     = exc_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    a_d      = issue_a;
                    b_d      = issue_b;
                    rd_d     = issue_rd;
                    is_div_d = issue_is_div;
                    state_d  = S_START;
                end
            end
            S_START: begin
                cnt_d     = '0;
                exc_d     = 1'b0;
                timeout_d = 1'b0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (md_ready) begin
                    result_d = md_result;
                    exc_d    = md_exception;
                    state_d  = S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (port_free) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        md_ctrl_mult = 1'b0;
        md_ctrl_div  = 1'b0;
        busy         = (state_q != S_IDLE);
        md_op_a      = a_q;
        md_op_b      = b_q;
        rf_we        = wb_we && (wb_rd != 5'd0);
        rf_waddr     = wb_rd;
        rf_wdata     = wb_data;
        case (state_q)
            S_IDLE:  stall = issue_valid;
            S_START: begin
                stall        = 1'b1;
                md_ctrl_div  = is_div_q;
                md_ctrl_mult = !is_div_q;
            end
            S_WAIT:  stall = 1'b1;
            S_WRITE: begin
                stall = 1'b1;
                if (port_free) begin
                    rf_we    = (pend_addr != 5'd0);
                    rf_waddr = pend_addr;
                    rf_wdata = pend_data;
                end
            end
            default: stall = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_multdiv_wb_ctrl.sv
// Bench for multdiv_wb_ctrl: directed vector table, reset-mid-op sequence and
// randomized ops checked against a rule-level model of the expected regfile write.
module tb_multdiv_wb_ctrl;
    localparam int MAX_WAIT = 64;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        issue_valid, issue_is_div;
    logic [31:0] issue_a, issue_b;
    logic [4:0]  issue_rd;
    logic        stall, md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_op_a, md_op_b, md_result;
    logic        md_exception, md_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multdiv_wb_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
        .stall(stall), .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_op_a(md_op_a), .md_op_b(md_op_b),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // delay = WAIT cycle (1-based) in which md_ready pulses; 0 = never (timeout)
    typedef struct packed {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [7:0]  delay;
        logic [31:0] result;
        logic        exc;
        logic [1:0]  conflicts;
        logic        noise;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Which regfile write an op must produce, from the architectural rules.
    function automatic void model_write(input logic is_div, input logic [4:0] rd,
                                        input logic [31:0] result, input logic exc,
                                        input logic timed_out, output logic we,
                                        output logic [4:0] addr, output logic [31:0] data);
        if (timed_out) begin
            we = 1'b1; addr = 5'd30; data = 32'd6;
        end else if (exc) begin
            we = 1'b1; addr = 5'd30; data = is_div ? 32'd5 : 32'd4;
        end else begin
            we = (rd != 5'd0); addr = rd; data = result;
        end
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int n;
        logic fire;
        // issue cycle (IDLE); an r0 pipeline write here must be suppressed
        @(negedge clock);
        issue_valid = 1'b1; issue_is_div = v.is_div; issue_a = v.a; issue_b = v.b;
        issue_rd = v.rd; wb_we = 1'b1; wb_rd = 5'd0; wb_data = $urandom; md_ready = 1'b0;
        #1;
        chk1({tag, " idle_busy"}, busy, 1'b0);
        chk1({tag, " issue_stall"}, stall, 1'b1);
        chk1({tag, " issue_nopulse"}, md_ctrl_mult | md_ctrl_div, 1'b0);
        chk1({tag, " r0_we"}, rf_we, 1'b0);
        // START: operand inputs now garbage and must be ignored
        @(negedge clock);
        issue_valid = 1'b1; issue_is_div = $urandom; issue_a = $urandom; issue_b = $urandom;
        issue_rd = $urandom; wb_we = 1'b0;
        md_ready = v.noise; md_result = 32'hDEAD_BEEF; md_exception = 1'b1;
        #1;
        chk1({tag, " start_mult"}, md_ctrl_mult, !v.is_div);
        chk1({tag, " start_div"}, md_ctrl_div, v.is_div);
        chk1({tag, " start_stall"}, stall, 1'b1);
        chk32({tag, " op_a"}, md_op_a, v.a);
        chk32({tag, " op_b"}, md_op_b, v.b);
        n = (v.delay == 0) ? MAX_WAIT : int'(v.delay);
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            fire = (v.delay != 0) && (i == n);
            md_ready = fire;
            md_result = fire ? v.result : $urandom;
            md_exception = fire ? v.exc : 1'b0;
            issue_a = $urandom;
            #1;
            chk1($sformatf("%s wait%0d_stall", tag, i), stall, 1'b1);
            chk1($sformatf("%s wait%0d_busy", tag, i), busy, 1'b1);
            chk1($sformatf("%s wait%0d_nopulse", tag, i), md_ctrl_mult | md_ctrl_div, 1'b0);
            chk1($sformatf("%s wait%0d_we", tag, i), rf_we, 1'b0);
        end
        for (int c = 0; c < int'(v.conflicts); c++) begin
            @(negedge clock);
            md_ready = 1'b0; md_result = $urandom;
            wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'h11;
            #1;
            chk1($sformatf("%s conflict%0d_we", tag, c), rf_we, 1'b1);
            chk32($sformatf("%s conflict%0d_addr", tag, c), {27'd0, rf_waddr}, 32'd8);
            chk32($sformatf("%s conflict%0d_data", tag, c), rf_wdata, 32'h11);
            chk1($sformatf("%s conflict%0d_stall", tag, c), stall, 1'b1);
        end
        // write cycle; a pipeline write to r0 leaves the port free
        @(negedge clock);
        md_ready = 1'b0; md_result = $urandom;
        wb_we = v.noise; wb_rd = 5'd0; wb_data = $urandom;
        #1;
        chk1({tag, " write_we"}, rf_we, v.exp_we);
        if (v.exp_we) begin
            chk32({tag, " write_addr"}, {27'd0, rf_waddr}, {27'd0, v.exp_addr});
            chk32({tag, " write_data"}, rf_wdata, v.exp_data);
        end
        chk1({tag, " write_stall"}, stall, 1'b1);
    endtask

    initial begin
        vec_t rv;
        reset_n = 1'b0; issue_valid = 1'b0; issue_is_div = 1'b0; issue_a = '0; issue_b = '0;
        issue_rd = '0; md_result = '0; md_exception = 1'b0; md_ready = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;

        //            div  a         b         rd  dly  result        exc cf noise we  addr  data
        vecs[0] = '{1'b0, 32'd7,  32'd6,  5'd3,  8'd3, 32'd42,      1'b0, 2'd0, 1'b0, 1'b1, 5'd3,  32'h2A};
        vecs[1] = '{1'b1, 32'd10, 32'd0,  5'd5,  8'd2, 32'd0,       1'b1, 2'd0, 1'b0, 1'b1, 5'd30, 32'd5};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h7, 5'd7, 8'd4, 32'd0,  1'b1, 2'd0, 1'b1, 1'b1, 5'd30, 32'd4};
        vecs[3] = '{1'b0, 32'd7,  32'd6,  5'd3,  8'd1, 32'd42,      1'b0, 2'd2, 1'b0, 1'b1, 5'd3,  32'd42};
        vecs[4] = '{1'b1, 32'd9,  32'd3,  5'd9,  8'd0, 32'd0,       1'b0, 2'd0, 1'b0, 1'b1, 5'd30, 32'd6};
        vecs[5] = '{1'b0, 32'hFF, 32'h101, 5'd0, 8'd2, 32'hFFFF,    1'b0, 2'd0, 1'b0, 1'b0, 5'd0,  32'd0};
        vecs[6] = '{1'b1, 32'h2468, 32'd2, 5'd12, 8'd5, 32'h1234,   1'b0, 2'd1, 1'b1, 1'b1, 5'd12, 32'h1234};
        vecs[7] = '{1'b1, 32'd1,  32'd0,  5'd0,  8'd1, 32'd0,       1'b1, 2'd0, 1'b0, 1'b1, 5'd30, 32'd5};

        repeat (5) @(negedge clock);
        #1;
        chk1("reset_stall", stall, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_pulse", md_ctrl_mult | md_ctrl_div, 1'b0);
        chk32("reset_op_a", md_op_a, 32'd0);
        chk32("reset_op_b", md_op_b, 32'd0);
        reset_n = 1'b1;

        // IDLE passthrough, and a stray md_ready in IDLE must not start anything
        @(negedge clock);
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'hCAFE_0001; md_ready = 1'b1;
        #1;
        chk1("pass_we", rf_we, 1'b1);
        chk32("pass_addr", {27'd0, rf_waddr}, 32'd9);
        chk32("pass_data", rf_wdata, 32'hCAFE_0001);
        @(negedge clock);
        md_ready = 1'b0; wb_we = 1'b0;
        #1;
        chk1("idle_ready_busy", busy, 1'b0);

        for (int k = 0; k < 8; k++) run_op(vecs[k], $sformatf("vec%0d", k));

        // reset in the middle of WAIT abandons the op
        @(negedge clock);
        issue_valid = 1'b1; issue_is_div = 1'b0; issue_a = 32'd3; issue_b = 32'd4; issue_rd = 5'd6;
        wb_we = 1'b0;
        repeat (4) @(negedge clock);
        issue_valid = 1'b0;
        #1;
        chk1("pre_rst_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_pulse", md_ctrl_mult | md_ctrl_div, 1'b0);
        chk1("rst_we", rf_we, 1'b0);
        chk32("rst_op_a", md_op_a, 32'd0);
        @(negedge clock);
        md_ready = 1'b1; md_result = 32'h77;
        @(negedge clock);
        reset_n = 1'b1; md_ready = 1'b0;
        @(negedge clock);
        #1;
        chk1("post_rst_busy", busy, 1'b0);
        chk1("post_rst_we", rf_we, 1'b0);
        run_op(vecs[0], "after_rst");

        for (int r = 0; r < 24; r++) begin
            rv.is_div = 1'($urandom);
            rv.a = $urandom; rv.b = $urandom; rv.rd = 5'($urandom);
            rv.delay = (r == 11) ? 8'd0 : 8'($urandom_range(1, 6));
            rv.result = $urandom;
            rv.exc = ($urandom_range(0, 5) == 0);
            rv.conflicts = 2'($urandom_range(0, 2));
            rv.noise = 1'($urandom);
            model_write(rv.is_div, rv.rd, rv.result, rv.exc, rv.delay == 0,
                        rv.exp_we, rv.exp_addr, rv.exp_data);
            run_op(rv, $sformatf("rand%0d", r));
        end

        @(negedge clock);
        issue_valid = 1'b0; wb_we = 1'b0; md_ready = 1'b0;
        #1;
        chk1("final_busy", busy, 1'b0);
        chk1("final_stall", stall, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
